hazard_tracker: RTL and testbench
=================================

Name: hazard_tracker

Overview:
- Consumer side of the Tuse/Tnew instruction decoder in the 5-stage MIPS pipeline (addu, subu, ori, lw, sw, beq, lui, jal, jr, j).
- Keeps a per-stage scoreboard of destination register and remaining Tnew for E, M and W.
- Compares the scoreboard with the D-stage Tuse values and drives the pipeline stall.
- Drives forwarding selects for the D, E and M operand paths and keeps a saturating stall-cycle counter.

Parameters:
- CNT_W, 16, width of the stall-cycle counter.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  synchronous reset, active-low.
- rs_d  in  5  rs field of the instruction in D.
- rt_d  in  5  rt field of the instruction in D.
- tuse_rs  in  2  Tuse of rs from the decoder; 3 means rs is not read.
- tuse_rt  in  2  Tuse of rt from the decoder; 3 means rt is not read.
- dst_d  in  5  destination register of the D instruction (rd, rt, or 31 for jal).
- tnew_d  in  2  Tnew the D instruction will have when it is in E; 3 means no register write.
- flush_e  in  1  inserts a bubble into E at the next edge (same effect as a stall on E).
- stall  out  1  freezes PC and the D register, and bubbles E.
- fwd_rs_d  out  2  D-stage rs source: 0 regfile, 1 E, 2 M.
- fwd_rt_d  out  2  D-stage rt source: 0 regfile, 1 E, 2 M.
- fwd_rs_e  out  2  E-stage rs source: 0 pipeline register, 1 M, 2 W.
- fwd_rt_e  out  2  E-stage rt source: 0 pipeline register, 1 M, 2 W.
- fwd_rt_m  out  1  M-stage store data: 0 pipeline register, 1 W.
- stall_cnt  out  CNT_W  number of stalled cycles, saturating.

Behaviour:
- State per stage X in {E, M, W}: dst_X (5 bits) and tnew_X (2 bits).
- E stage also holds rs_e and rt_e; M stage also holds rt_m.
- Bubble value: dst 0, tnew 3, rs/rt 0.
- Reset (rst_n low at an edge): all stages take the bubble value and stall_cnt clears to 0. Reset overrides stall and flush in the same cycle.
- Because every output is derived from state, all outputs are 0 in the cycle after reset.
- Every edge:
  - W takes M, with tnew decremented.
  - M takes E, with tnew decremented.
  - Decrement rule: 3 stays 3; 0 stays 0; otherwise tnew-1.
- E register:
  - Normal: E takes {dst_d, tnew_d, rs_d, rt_d}.
  - If stall or flush_e is high: E takes the bubble value.
- A stage "writes r" when dst_X == r, r != 0, and tnew_X != 3.
- Stall rule for the rs operand: stall if tuse_rs != 3 and either
  - E writes rs_d with tnew_E > tuse_rs, or
  - M writes rs_d with tnew_M > tuse_rs.
- The rt operand uses the identical rule. stall is the OR of both, and is purely combinational from inputs and state.
- W never causes a stall.
- Nearest-stage rule: if E writes a register, M and W are ignored for that register.
  - Example: E holds lw to r5 (tnew 2), M holds addu to r5 (tnew 0), D holds beq on r5. The result is stall, with no forward from M.
- D-stage forwarding, per operand:
  - 1 if E writes the register and tnew_E == 0.
  - Else 2 if M writes it and tnew_M == 0.
  - Else 0.
  - The W-to-D path uses the regfile's write-through, so it never forwards here.
- E-stage forwarding, per operand: compare rs_e/rt_e against M, then W; pick the nearest writer with tnew == 0; otherwise 0.
- M-stage forwarding: fwd_rt_m = 1 if W writes rt_m with tnew_W == 0.
- Forward selects remain valid while stall is high; the stall decision takes precedence in the pipeline.
- Stall counter: stall_cnt increments on every edge where stall == 1 and holds at all ones.
- Simultaneous stall and flush_e: a single bubble is inserted and the counter still increments.

Decomposition:
- Shared package hazard_pkg:
  - TNEW_NONE = 2'd3 and TUSE_NONE = 2'd3.
  - Forward-select encodings: FWD_D_RF/E/M and FWD_E_REG/M/W.
  - stage_rec_t struct: dst[4:0], tnew[1:0].
  - BUBBLE constant.
- One natural sub-module: hazard_match. Pure combinational; takes (reg, tuse, stage records) and returns (stall_req, fwd_sel). It is instantiated for rs and for rt.

Test Plan:
- lw r5 in D, then addu r6,r5,r1: tnew_E = 2 > tuse 1, so stall = 1 for exactly one cycle. Next cycle: M tnew 1 > 1 is false, so no stall, and fwd_rs_e = 2 once addu is in E. stall_cnt = 1.
- lw r5, then beq r5,r0: stalls 2 cycles (E tnew 2, then M tnew 1 > 0). On the third cycle, lw is in W and fwd_rs_d = 0 (regfile write-through). stall_cnt = 2.
- addu r3, then beq r3: one stall (E tnew 1 > 0). Next cycle M tnew 0, so fwd_rs_d = 2.
- jal in D, then jr r31 follows: E tnew 0, so no stall and fwd_rs_d = 1.
- Writers to r0 and sw/beq (tnew 3) into registers read by the next instruction: never stall, all fwd = 0.
- Reset asserted mid-stall, and flush_e with stall: after reset, stall = 0, all fwd = 0, stall_cnt = 0. With CNT_W = 2, forcing 5 stall cycles gives stall_cnt = 3 and it holds.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared types, encodings and helpers for the pipeline hazard tracker.
package hazard_pkg;

  localparam logic [1:0] TNEW_NONE = 2'd3;
  localparam logic [1:0] TUSE_NONE = 2'd3;

  // D-stage operand sources
  localparam logic [1:0] FWD_D_RF = 2'd0;
  localparam logic [1:0] FWD_D_E  = 2'd1;
  localparam logic [1:0] FWD_D_M  = 2'd2;

  // E-stage operand sources
  localparam logic [1:0] FWD_E_REG = 2'd0;
  localparam logic [1:0] FWD_E_M   = 2'd1;
  localparam logic [1:0] FWD_E_W   = 2'd2;

  typedef struct packed {
    logic [4:0] dst;
    logic [1:0] tnew;
  } stage_rec_t;

  localparam stage_rec_t BUBBLE = '{dst: 5'd0, tnew: TNEW_NONE};

  // A stage produces r only for a real, non-zero destination with a pending write.
  function automatic logic writes(input stage_rec_t s, input logic [4:0] r);
    return (s.dst == r) && (r != 5'd0) && (s.tnew != TNEW_NONE);
  endfunction

  // Tnew counts down toward 0 and stays there; "no write" stays "no write".
  function automatic logic [1:0] tnew_dec(input logic [1:0] t);
    if (t == TNEW_NONE || t == 2'd0) return t;
    return t - 2'd1;
  endfunction

  function automatic stage_rec_t age(input stage_rec_t s);
    stage_rec_t r;
    r.dst  = s.dst;
    r.tnew = tnew_dec(s.tnew);
    return r;
  endfunction

endpackage

// File: rtl/hazard_match.sv
// Per-operand hazard check for the D stage against the E and M scoreboard
// entries. E is the nearer producer, so when E writes the register M is ignored.
module hazard_match
  import hazard_pkg::*;
(
  input  logic [4:0] src_reg,
  input  logic [1:0] tuse,
  input  stage_rec_t rec_e,
  input  stage_rec_t rec_m,
  output logic       stall_req,
  output logic [1:0] fwd_sel
);

  logic hit_e;
  logic hit_m;
  logic reads;

  assign hit_e = writes(rec_e, src_reg);
  assign hit_m = writes(rec_m, src_reg);
  assign reads = (tuse != TUSE_NONE);

  // Nearest producer decides both the stall and the forward source.
  always_comb begin
    stall_req = 1'b0;
    fwd_sel   = FWD_D_RF;
    if (hit_e) begin
      if (rec_e.tnew == 2'd0) fwd_sel = FWD_D_E;
      if (reads && (rec_e.tnew > tuse)) stall_req = 1'b1;
    end else if (hit_m) begin
      if (rec_m.tnew == 2'd0) fwd_sel = FWD_D_M;
      if (reads && (rec_m.tnew > tuse)) stall_req = 1'b1;
    end
  end

endmodule

// File: rtl/hazard_tracker.sv
// Tnew/Tuse scoreboard for a 5-stage pipeline: tracks E/M/W producers,
// raises the D-stage stall, drives forwarding selects and counts stall cycles.
module hazard_tracker
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       rs_d,
  input  logic [4:0]       rt_d,
  input  logic [1:0]       tuse_rs,
  input  logic [1:0]       tuse_rt,
  input  logic [4:0]       dst_d,
  input  logic [1:0]       tnew_d,
  input  logic             flush_e,
  output logic             stall,
  output logic [1:0]       fwd_rs_d,
  output logic [1:0]       fwd_rt_d,
  output logic [1:0]       fwd_rs_e,
  output logic [1:0]       fwd_rt_e,
  output logic             fwd_rt_m,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  stage_rec_t rec_e;
  stage_rec_t rec_m;
  stage_rec_t rec_w;
  logic [4:0] rs_e;
  logic [4:0] rt_e;
  logic [4:0] rt_m;

  logic stall_rs;
  logic stall_rt;

  hazard_match u_match_rs (
    .src_reg   (rs_d),
    .tuse      (tuse_rs),
    .rec_e     (rec_e),
    .rec_m     (rec_m),
    .stall_req (stall_rs),
    .fwd_sel   (fwd_rs_d)
  );

  hazard_match u_match_rt (
    .src_reg   (rt_d),
    .tuse      (tuse_rt),
    .rec_e     (rec_e),
    .rec_m     (rec_m),
    .stall_req (stall_rt),
    .fwd_sel   (fwd_rt_d)
  );

  assign stall = stall_rs | stall_rt;

  // E-stage operand source: nearest of M then W, only once its result exists.
  function automatic logic [1:0] fwd_e_sel(input logic [4:0] r,
                                           input stage_rec_t m,
                                           input stage_rec_t w);
    if (writes(m, r)) return (m.tnew == 2'd0) ? FWD_E_M : FWD_E_REG;
    if (writes(w, r) && (w.tnew == 2'd0)) return FWD_E_W;
    return FWD_E_REG;
  endfunction

  // Forward selects for the E and M operand paths, all from registered state.
  always_comb begin
    fwd_rs_e = fwd_e_sel(rs_e, rec_m, rec_w);
    fwd_rt_e = fwd_e_sel(rt_e, rec_m, rec_w);
    fwd_rt_m = writes(rec_w, rt_m) && (rec_w.tnew == 2'd0);
  end

  // Pipeline advance of the scoreboard; a stall or flush drops a bubble into E.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rec_e <= BUBBLE;
      rec_m <= BUBBLE;
      rec_w <= BUBBLE;
      rs_e  <= 5'd0;
      rt_e  <= 5'd0;
      rt_m  <= 5'd0;
    end else begin
      rec_w <= age(rec_m);
      rec_m <= age(rec_e);
      rt_m  <= rt_e;
      if (stall || flush_e) begin
        rec_e <= BUBBLE;
        rs_e  <= 5'd0;
        rt_e  <= 5'd0;
      end else begin
        rec_e <= '{dst: dst_d, tnew: tnew_d};
        rs_e  <= rs_d;
        rt_e  <= rt_d;
      end
    end
  end

  // Saturating count of stalled cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt <= '0;
    end else if (stall && (stall_cnt != CNT_MAX)) begin
      stall_cnt <= stall_cnt + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_tracker.sv
// Self-checking bench for hazard_tracker: directed pipeline scenarios plus
// randomized traffic, checked against an instruction-level pipeline model.
module tb_hazard_tracker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [4:0] rs_d, rt_d, dst_d;
  logic [1:0] tuse_rs, tuse_rt, tnew_d;
  logic       flush_e, rst_n;

  logic        stall, fwd_rt_m;
  logic [1:0]  fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e;
  logic [15:0] stall_cnt;

  logic        stall2, fwd_rt_m2;
  logic [1:0]  fwd_rs_d2, fwd_rt_d2, fwd_rs_e2, fwd_rt_e2;
  logic [1:0]  stall_cnt2;

  hazard_tracker #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .dst_d(dst_d), .tnew_d(tnew_d),
    .flush_e(flush_e), .stall(stall), .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d),
    .fwd_rs_e(fwd_rs_e), .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m),
    .stall_cnt(stall_cnt)
  );

  hazard_tracker #(.CNT_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .rs_d(rs_d), .rt_d(rt_d),
    .tuse_rs(tuse_rs), .tuse_rt(tuse_rt), .dst_d(dst_d), .tnew_d(tnew_d),
    .flush_e(flush_e), .stall(stall2), .fwd_rs_d(fwd_rs_d2), .fwd_rt_d(fwd_rt_d2),
    .fwd_rs_e(fwd_rs_e2), .fwd_rt_e(fwd_rt_e2), .fwd_rt_m(fwd_rt_m2),
    .stall_cnt(stall_cnt2)
  );

  int vectors = 0;
  int miscompares = 0;

  // Model: in-flight instructions in E (0), M (1), W (2).
  typedef struct {
    int dst;
    int tnew;
    int rs;
    int rt;
  } ent_t;

  ent_t pipe[3];
  bit   model_ok = 0;
  int   cnt_model = 0;
  int   cnt2_model = 0;

  // Values observed at the last step (sampled 1 ns after inputs change).
  logic [31:0] obs[8];
  string       names[8] = '{"stall", "fwd_rs_d", "fwd_rt_d", "fwd_rs_e",
                            "fwd_rt_e", "fwd_rt_m", "stall_cnt", "stall_cnt_sat"};

  function automatic int nearest(int r, int lo, int hi);
    for (int i = lo; i <= hi; i++)
      if (r != 0 && pipe[i].dst == r && pipe[i].tnew != 3) return i;
    return -1;
  endfunction

  // Source number: 1 for the nearest stage in the window, 2 for the next.
  function automatic int src_of(int r, int lo, int hi);
    int k = nearest(r, lo, hi);
    if (k >= 0 && pipe[k].tnew == 0) return k - lo + 1;
    return 0;
  endfunction

  function automatic int needs_stall(int r, int tuse);
    int k;
    if (tuse == 3) return 0;
    k = nearest(r, 0, 1);
    return (k >= 0 && pipe[k].tnew > tuse) ? 1 : 0;
  endfunction

  function automatic ent_t aged(ent_t e);
    ent_t r = e;
    if (r.tnew == 1 || r.tnew == 2) r.tnew = r.tnew - 1;
    return r;
  endfunction

  task automatic step(input int a_rs, input int a_rt, input int a_tr, input int a_tt,
                      input int a_dst, input int a_tn, input bit fl, input bit rb);
    int want[8];
    int st;
    ent_t bub, nw;
    rs_d = 5'(a_rs); rt_d = 5'(a_rt); tuse_rs = 2'(a_tr); tuse_rt = 2'(a_tt);
    dst_d = 5'(a_dst); tnew_d = 2'(a_tn); flush_e = fl; rst_n = rb;
    #1;
    obs[0] = 32'(stall);     obs[1] = 32'(fwd_rs_d); obs[2] = 32'(fwd_rt_d);
    obs[3] = 32'(fwd_rs_e);  obs[4] = 32'(fwd_rt_e); obs[5] = 32'(fwd_rt_m);
    obs[6] = 32'(stall_cnt); obs[7] = 32'(stall_cnt2);
    st = needs_stall(a_rs, a_tr) | needs_stall(a_rt, a_tt);
    if (model_ok) begin
      want[0] = st;
      want[1] = src_of(a_rs, 0, 1);
      want[2] = src_of(a_rt, 0, 1);
      want[3] = src_of(pipe[0].rs, 1, 2);
      want[4] = src_of(pipe[0].rt, 1, 2);
      want[5] = src_of(pipe[1].rt, 2, 2);
      want[6] = cnt_model;
      want[7] = cnt2_model;
      for (int i = 0; i < 8; i++) begin
        vectors++;
        if (obs[i] !== 32'(want[i])) begin
          miscompares++;
          $display("FAIL %s at %0t: got %0d want %0d", names[i], $time, obs[i], want[i]);
        end
      end
    end
    @(posedge clk);
    bub = '{dst: 0, tnew: 3, rs: 0, rt: 0};
    if (!rb) begin
      pipe[0] = bub; pipe[1] = bub; pipe[2] = bub;
      cnt_model = 0; cnt2_model = 0; model_ok = 1;
    end else if (model_ok) begin
      nw = '{dst: a_dst, tnew: a_tn, rs: a_rs, rt: a_rt};
      pipe[2] = aged(pipe[1]);
      pipe[1] = aged(pipe[0]);
      pipe[0] = (st != 0 || fl) ? bub : nw;
      if (st != 0) begin
        if (cnt_model < 65535) cnt_model++;
        if (cnt2_model < 3) cnt2_model++;
      end
    end
    @(negedge clk);
  endtask

  task automatic issue(input int dst, input int tn, input int rs, input int rt,
                       input int tr, input int tt);
    step(rs, rt, tr, tt, dst, tn, 1'b0, 1'b1);
  endtask

  task automatic nop();
    issue(0, 3, 0, 0, 3, 3);
  endtask

  task automatic do_reset();
    step(0, 0, 3, 3, 0, 3, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    do_reset();
    nop();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs[i] !== 32'd0) begin
        miscompares++;
        $display("FAIL reset_%s: got %0d want 0", names[i], obs[i]);
      end
    end
  endtask

  // lw r5,0(r1); addu r6,r5,r1
  task automatic test_load_use();
    do_reset();
    issue(5, 2, 1, 5, 1, 3);
    issue(6, 1, 5, 1, 1, 1);
    vectors++; if (obs[0] !== 1) begin miscompares++; $display("FAIL lu_stall1: got %0d want 1", obs[0]); end
    issue(6, 1, 5, 1, 1, 1);
    vectors++; if (obs[0] !== 0) begin miscompares++; $display("FAIL lu_stall2: got %0d want 0", obs[0]); end
    nop();
    vectors++; if (obs[3] !== 2) begin miscompares++; $display("FAIL lu_fwd_rs_e: got %0d want 2", obs[3]); end
    vectors++; if (obs[6] !== 1) begin miscompares++; $display("FAIL lu_cnt: got %0d want 1", obs[6]); end
  endtask

  // lw r5; beq r5,r0
  task automatic test_load_branch();
    do_reset();
    issue(5, 2, 1, 5, 1, 3);
    for (int i = 0; i < 2; i++) begin
      issue(0, 3, 5, 0, 0, 0);
      vectors++; if (obs[0] !== 1) begin miscompares++; $display("FAIL lb_stall%0d: got %0d want 1", i, obs[0]); end
    end
    issue(0, 3, 5, 0, 0, 0);
    vectors++; if (obs[0] !== 0 || obs[1] !== 0) begin miscompares++; $display("FAIL lb_release: got stall %0d fwd %0d want 0 0", obs[0], obs[1]); end
    nop();
    vectors++; if (obs[6] !== 2) begin miscompares++; $display("FAIL lb_cnt: got %0d want 2", obs[6]); end
  endtask

  // addu r3; beq r3,r0  then  jal; jr r31
  task automatic test_alu_branch_jal();
    do_reset();
    issue(3, 1, 1, 2, 1, 1);
    issue(0, 3, 3, 0, 0, 0);
    vectors++; if (obs[0] !== 1) begin miscompares++; $display("FAIL ab_stall: got %0d want 1", obs[0]); end
    issue(0, 3, 3, 0, 0, 0);
    vectors++; if (obs[0] !== 0 || obs[1] !== 2) begin miscompares++; $display("FAIL ab_fwd: got stall %0d fwd %0d want 0 2", obs[0], obs[1]); end
    do_reset();
    issue(31, 0, 0, 0, 3, 3);
    issue(0, 3, 31, 0, 0, 3);
    vectors++; if (obs[0] !== 0 || obs[1] !== 1) begin miscompares++; $display("FAIL jr_fwd: got stall %0d fwd %0d want 0 1", obs[0], obs[1]); end
  endtask

  // Writers to r0 and non-writers (sw) never stall or forward.
  task automatic test_no_hazard();
    do_reset();
    issue(0, 1, 1, 2, 1, 1);
    issue(7, 1, 0, 0, 0, 0);
    vectors++; if (obs[0] !== 0 || obs[1] !== 0 || obs[2] !== 0) begin miscompares++; $display("FAIL r0_writer: got %0d %0d %0d want 0 0 0", obs[0], obs[1], obs[2]); end
    issue(4, 3, 2, 4, 1, 2);
    issue(9, 1, 4, 4, 0, 0);
    vectors++; if (obs[0] !== 0 || obs[1] !== 0 || obs[2] !== 0) begin miscompares++; $display("FAIL sw_nowrite: got %0d %0d %0d want 0 0 0", obs[0], obs[1], obs[2]); end
    nop();
    vectors++; if (obs[3] !== 0 || obs[4] !== 0) begin miscompares++; $display("FAIL sw_fwd_e: got %0d %0d want 0 0", obs[3], obs[4]); end
  endtask

  // Nearest producer wins: lw r5 in E shadows addu r5 in M.
  task automatic test_nearest();
    do_reset();
    issue(5, 1, 1, 2, 1, 1);
    issue(5, 2, 1, 5, 1, 3);
    issue(0, 3, 5, 0, 0, 0);
    vectors++; if (obs[0] !== 1 || obs[1] !== 0) begin miscompares++; $display("FAIL nearest: got stall %0d fwd %0d want 1 0", obs[0], obs[1]); end
  endtask

  task automatic test_reset_flush();
    do_reset();
    issue(5, 2, 1, 5, 1, 3);
    step(5, 1, 1, 1, 6, 1, 1'b0, 1'b0);
    nop();
    for (int i = 0; i < 8; i++) begin
      vectors++;
      if (obs[i] !== 32'd0) begin
        miscompares++;
        $display("FAIL midstall_reset_%s: got %0d want 0", names[i], obs[i]);
      end
    end
    issue(5, 2, 1, 5, 1, 3);
    step(5, 1, 1, 1, 6, 1, 1'b1, 1'b1);
    vectors++; if (obs[0] !== 1) begin miscompares++; $display("FAIL flush_stall: got %0d want 1", obs[0]); end
    issue(6, 1, 5, 1, 1, 1);
    vectors++; if (obs[0] !== 0 || obs[6] !== 1) begin miscompares++; $display("FAIL flush_cnt: got stall %0d cnt %0d want 0 1", obs[0], obs[6]); end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int n = 0; n < 3; n++) begin
      issue(5, 2, 1, 5, 1, 3);
      for (int i = 0; i < 3; i++) issue(0, 3, 5, 0, 0, 0);
    end
    nop();
    vectors++; if (obs[7] !== 3) begin miscompares++; $display("FAIL sat_cnt2: got %0d want 3", obs[7]); end
    vectors++; if (obs[6] !== 6) begin miscompares++; $display("FAIL sat_cnt16: got %0d want 6", obs[6]); end
    nop();
    vectors++; if (obs[7] !== 3) begin miscompares++; $display("FAIL sat_hold: got %0d want 3", obs[7]); end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      step($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 3),
           $urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 3),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) != 0));
    end
  endtask

  initial begin
    rst_n = 1'b0; flush_e = 1'b0;
    rs_d = '0; rt_d = '0; dst_d = '0; tuse_rs = 2'd3; tuse_rt = 2'd3; tnew_d = 2'd3;
    @(negedge clk);
    test_reset();
    test_load_use();
    test_load_branch();
    test_alu_branch_jal();
    test_no_hazard();
    test_nearest();
    test_reset_flush();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
